// File: rtl/seq_defs.sv
// Shared encodings for the instruction sequencer: state codes,
// opcodes and the ALU operation field.
package seq_defs;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_HALT   = 4'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_LD  = 3'b100,
        OP_ST  = 3'b101,
        OP_BEQ = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/wait_timer.sv
// Memory-handshake wait counter; expired fires on the TIMEOUT-th
// consecutive waiting cycle, unless the handshake lands that cycle.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic Clock,
    input  logic Clear,
    input  logic restart,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = count_en && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback
// with a bounded memory handshake and a saturating retire counter.
module instruction_sequencer
    import seq_defs::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       Start,
    input  logic [2:0] OPCODE,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IR_load,
    output logic       PC_inc,
    output logic       PC_load,
    output logic       RegWrite,
    output logic [1:0] ALUop,
    output logic [3:0] State,
    output logic       Halted,
    output logic       BusError,
    output logic [7:0] InstrCount
);

    state_t     r_state;
    logic [7:0] r_icount;
    logic       r_buserr;
    opcode_t    w_op;
    logic       w_waiting;
    logic       w_expired;
    logic       w_retire;

    assign w_op      = opcode_t'(OPCODE);
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);

    // Restarting on a completed handshake keeps MEM->FETCH from inheriting a stale count
    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .Clock    (Clock),
        .Clear    (Clear),
        .restart  (!w_waiting || MemReady),
        .count_en (w_waiting && !MemReady),
        .expired  (w_expired)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state  <= S_IDLE;
            r_icount <= 8'd0;
            r_buserr <= 1'b0;
        end else begin
            if (w_retire && r_icount != 8'hFF) begin
                r_icount <= r_icount + 8'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (Start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (MemReady) begin
                        r_state <= S_DECODE;
                    end else if (w_expired) begin
                        r_state  <= S_HALT;
                        r_buserr <= 1'b1;
                    end
                end
                S_DECODE: begin
                    unique case (w_op)
                        OP_LD, OP_ST: r_state <= S_MEM;
                        OP_HLT:       r_state <= S_HALT;
                        default:      r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    r_state <= (w_op == OP_BEQ) ? S_FETCH : S_WB;
                end
                S_MEM: begin
                    if (MemReady) begin
                        r_state <= (w_op == OP_LD) ? S_WB : S_FETCH;
                    end else if (w_expired) begin
                        r_state  <= S_HALT;
                        r_buserr <= 1'b1;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IR_load  = 1'b0;
        PC_inc   = 1'b0;
        PC_load  = 1'b0;
        RegWrite = 1'b0;
        ALUop    = ALU_ADD;
        w_retire = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IR_load = MemReady;
                PC_inc  = MemReady;
            end
            S_EXEC: begin
                if (w_op == OP_BEQ) begin
                    ALUop    = ALU_SUB;
                    PC_load  = Zero;
                    w_retire = 1'b1;
                end else begin
                    ALUop = OPCODE[1:0];
                end
            end
            S_MEM: begin
                MemRead  = (w_op == OP_LD);
                MemWrite = (w_op == OP_ST);
                w_retire = (w_op == OP_ST) && MemReady;
            end
            S_WB: begin
                RegWrite = 1'b1;
                w_retire = 1'b1;
            end
            default: ;
        endcase
    end

    assign State      = r_state;
    assign Halted     = (r_state == S_HALT);
    assign BusError   = r_buserr;
    assign InstrCount = r_icount;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: walks each instruction
// class, handshake timeout boundary, async clear and count saturation.
module tb_instruction_sequencer;

    logic       Clock;
    logic       Clear;
    logic       Start;
    logic [2:0] OPCODE;
    logic       Zero;
    logic       MemReady;
    logic       MemRead;
    logic       MemWrite;
    logic       IR_load;
    logic       PC_inc;
    logic       PC_load;
    logic       RegWrite;
    logic [1:0] ALUop;
    logic [3:0] State;
    logic       Halted;
    logic       BusError;
    logic [7:0] InstrCount;

    int n_cmp = 0;
    int n_err = 0;

    instruction_sequencer #(.TIMEOUT(15)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .Start      (Start),
        .OPCODE     (OPCODE),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IR_load    (IR_load),
        .PC_inc     (PC_inc),
        .PC_load    (PC_load),
        .RegWrite   (RegWrite),
        .ALUop      (ALUop),
        .State      (State),
        .Halted     (Halted),
        .BusError   (BusError),
        .InstrCount (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Clear = 1'b0; Start = 1'b0; OPCODE = 3'b000;
        Zero = 1'b0; MemReady = 1'b0;
        #1;
        chk("rst_state", {4'd0, State}, 8'd0);
        chk("rst_count", InstrCount, 8'd0);
        chk("rst_flags", {6'd0, Halted, BusError}, 8'd0);
        chk("rst_strobe", {6'd0, MemRead, MemWrite}, 8'd0);
        step();
        Clear = 1'b1;
        step();
        chk("idle_no_start", {4'd0, State}, 8'd0);

        // ADD with immediate MemReady: 0,1,2,3,5,1
        Start = 1'b1; OPCODE = 3'b000; MemReady = 1'b1;
        step();
        Start = 1'b0;
        #1;
        chk("add_fetch", {4'd0, State}, 8'd1);
        chk("add_irload", {6'd0, IR_load, PC_inc}, 8'd3);
        chk("add_memrd", {7'd0, MemRead}, 8'd1);
        step();
        MemReady = 1'b0;
        #1;
        chk("add_decode", {4'd0, State}, 8'd2);
        step();
        chk("add_exec", {4'd0, State}, 8'd3);
        chk("add_aluop", {6'd0, ALUop}, 8'd0);
        step();
        chk("add_wb", {4'd0, State}, 8'd5);
        chk("add_regwr", {7'd0, RegWrite}, 8'd1);
        chk("add_cnt_pre", InstrCount, 8'd0);
        step();
        chk("add_back", {4'd0, State}, 8'd1);
        chk("add_regwr_off", {7'd0, RegWrite}, 8'd0);
        chk("add_cnt", InstrCount, 8'd1);

        // LD, MemReady arrives on 4th MEM cycle
        OPCODE = 3'b100; MemReady = 1'b1;
        step();
        MemReady = 1'b0;
        step();
        chk("ld_mem", {4'd0, State}, 8'd4);
        for (int i = 0; i < 3; i++) begin
            chk("ld_memrd_wait", {6'd0, MemRead, MemWrite}, 8'd2);
            step();
        end
        MemReady = 1'b1;
        #1;
        chk("ld_memrd_last", {6'd0, MemRead, MemWrite}, 8'd2);
        step();
        MemReady = 1'b0;
        #1;
        chk("ld_wb", {4'd0, State}, 8'd5);
        chk("ld_memrd_off", {7'd0, MemRead}, 8'd0);
        chk("ld_cnt_pre", InstrCount, 8'd1);
        step();
        chk("ld_cnt", InstrCount, 8'd2);

        // BEQ taken then not taken
        OPCODE = 3'b110; Zero = 1'b1; MemReady = 1'b1;
        step();
        MemReady = 1'b0;
        step();
        chk("beq1_exec", {4'd0, State}, 8'd3);
        chk("beq1_aluop", {6'd0, ALUop}, 8'd1);
        chk("beq1_pcload", {7'd0, PC_load}, 8'd1);
        step();
        chk("beq1_fetch", {4'd0, State}, 8'd1);
        chk("beq1_pcl_off", {7'd0, PC_load}, 8'd0);
        chk("beq1_cnt", InstrCount, 8'd3);
        Zero = 1'b0; MemReady = 1'b1;
        step();
        MemReady = 1'b0;
        step();
        chk("beq2_exec", {4'd0, State}, 8'd3);
        chk("beq2_pcload", {7'd0, PC_load}, 8'd0);
        step();
        chk("beq2_fetch", {4'd0, State}, 8'd1);
        chk("beq2_cnt", InstrCount, 8'd4);

        // ST interrupted by Clear mid-access
        OPCODE = 3'b101; MemReady = 1'b1;
        step();
        MemReady = 1'b0;
        step();
        chk("st_mem", {4'd0, State}, 8'd4);
        chk("st_memwr", {6'd0, MemRead, MemWrite}, 8'd1);
        step();
        #2;
        Clear = 1'b0;
        #1;
        chk("clr_memwr", {7'd0, MemWrite}, 8'd0);
        chk("clr_state", {4'd0, State}, 8'd0);
        chk("clr_count", InstrCount, 8'd0);
        Clear = 1'b1;
        step();
        chk("clr_idle", {4'd0, State}, 8'd0);

        // Handshake on the last allowed waiting cycle is a success
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("edge_still_fetch", {4'd0, State}, 8'd1);
        OPCODE = 3'b000; MemReady = 1'b1;
        step();
        MemReady = 1'b0;
        #1;
        chk("edge_decode", {4'd0, State}, 8'd2);
        chk("edge_noerr", {7'd0, BusError}, 8'd0);
        step(); step(); step();
        chk("edge_cnt", InstrCount, 8'd1);

        // FETCH timeout
        for (int i = 0; i < 14; i++) step();
        chk("to_fetch14", {4'd0, State}, 8'd1);
        step();
        chk("to_halt", {4'd0, State}, 8'd6);
        chk("to_flags", {6'd0, Halted, BusError}, 8'd3);
        chk("to_strobes", {6'd0, MemRead, MemWrite}, 8'd0);
        Start = 1'b1;
        step();
        step();
        Start = 1'b0;
        chk("to_start_ign", {4'd0, State}, 8'd6);

        // 256 ADDs then HLT: count saturates
        Clear = 1'b0;
        #2;
        Clear = 1'b1;
        chk("sat_rst_err", {7'd0, BusError}, 8'd0);
        Start = 1'b1; OPCODE = 3'b000; MemReady = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 255; i++) begin
            step(); step(); step(); step();
        end
        chk("sat_255", InstrCount, 8'd255);
        step(); step(); step(); step();
        chk("sat_256", InstrCount, 8'd255);
        OPCODE = 3'b111;
        step();
        chk("hlt_decode", {4'd0, State}, 8'd2);
        step();
        chk("hlt_state", {4'd0, State}, 8'd6);
        chk("hlt_flags", {6'd0, Halted, BusError}, 8'd2);
        chk("hlt_count", InstrCount, 8'd255);
        chk("hlt_strobes", {2'd0, MemRead, MemWrite, IR_load, PC_inc,
                            PC_load, RegWrite}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15, sets the maximum cycles to wait for MemReady before a bus error.
REQ-002 Clock  input  1  system clock; all state changes occur on the rising edge.
REQ-003 Clear  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  begin execution from IDLE; ignored in every other state.
REQ-005 OPCODE  input  3  opcode field from the instruction register.
REQ-006 Zero  input  1  ALU zero flag, sampled in EXEC.
REQ-007 MemReady  input  1  memory access-complete handshake.
REQ-008 MemRead, MemWrite  output  1 each  memory strobes.
REQ-009 IR_load, PC_inc, PC_load, RegWrite  output  1 each  datapath load enables.
REQ-010 ALUop  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-011 State  output  4  current state code.
REQ-012 Halted, BusError  output  1 each  status flags.
REQ-013 InstrCount  output  8  count of retired instructions.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT, encoded 0 to 6 on State.
REQ-015 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LD, 101 ST, 110 BEQ, 111 HLT.
REQ-016 IDLE SHALL go to FETCH on the edge after Start=1; otherwise it stays in IDLE.
REQ-017 FETCH SHALL assert MemRead; when MemReady=1, IR_load=1 and PC_inc=1 in the same cycle (combinational) and the next state is DECODE.
REQ-018 DECODE SHALL last exactly one cycle: opcodes 000-011 and 110 go to EXEC, 100/101 go to MEM, 111 goes to HALT.
REQ-019 EXEC SHALL drive ALUop = OPCODE[1:0] for ALU ops and 01 for BEQ; ALU ops go to WB; BEQ asserts PC_load iff Zero=1, then goes to FETCH.
REQ-020 MEM SHALL assert MemRead (LD) or MemWrite (ST) until MemReady=1; LD then goes to WB, ST to FETCH.
REQ-021 WB SHALL assert RegWrite for exactly one cycle, then go to FETCH.
REQ-022 InstrCount SHALL increment on the retire edge (WB exit, ST MEM exit, BEQ EXEC exit) and saturate at 255.
REQ-023 Wait counter: cleared on entry to FETCH or MEM; increments each cycle with MemReady=0; when the count reaches TIMEOUT, go to HALT and set BusError.
REQ-024 MemReady=1 in the same cycle the count reaches TIMEOUT SHALL count as success; no error.
REQ-025 HALT SHALL assert Halted, drive all strobes 0, and hold until Clear; Start is ignored.
REQ-026 Strobes SHALL never be active outside the states named above; MemRead and MemWrite are never both 1.
REQ-027 OPCODE SHALL be sampled only in DECODE and while in EXEC/MEM; it is assumed stable from DECODE to retire.

Reset
REQ-028 Clear=0 SHALL immediately force IDLE, InstrCount=0, wait counter=0, BusError=0, Halted=0 and all strobes 0, including mid-access.
REQ-029 On Clear release, the first state change SHALL need Start=1 on a rising edge.

Structure
REQ-030 State codes, opcode constants and the ALUop encoding SHALL live in shared package seq_defs, also used by the datapath top.
REQ-031 The wait counter with terminal-count compare SHALL be sub-module wait_timer (parameter TIMEOUT, ports Clock, Clear, restart, count_en, expired).
REQ-032 The RTL SHALL be one sequential next-state/counter process plus one combinational output decode.

Verification
REQ-033 Start, ADD (000), MemReady on the first FETCH cycle -> States 0,1,2,3,5,1; RegWrite=1 for one cycle; InstrCount=1.
REQ-034 LD with MemReady delayed 3 cycles in MEM -> MemRead high 4 cycles, then WB; InstrCount increments once.
REQ-035 BEQ with Zero=1, then BEQ with Zero=0 -> PC_load=1 exactly once (first only); each takes 3 cycles after FETCH.
REQ-036 MemReady held 0 in FETCH -> HALT after 15 waiting cycles; BusError=1, Halted=1; Start ignored afterwards.
REQ-037 Clear pulsed low mid-MEM during ST -> MemWrite drops asynchronously; State=0, InstrCount=0.
REQ-038 HLT (111) after 256 ADDs -> InstrCount=255 (saturated); Halted=1, BusError=0.
